// File: rtl/pwm_step_sequencer.sv
// Step-table PWM sequencer: plays DEPTH-entry {period, high, repeats} steps back to back on opin.
// Define PWM_STEP_SEQUENCER_LOOP_EN to add the `loop` input for continuous replay.
module pwm_step_sequencer #(
  parameter int CNT_W  = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_reps,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              start,
  input  logic              stop,
`ifdef PWM_STEP_SEQUENCER_LOOP_EN
  input  logic              loop,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] step_idx,
  output logic              opin
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] STEP_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  period_q [DEPTH];
  logic [CNT_W-1:0]  period_d [DEPTH];
  logic [CNT_W-1:0]  high_q   [DEPTH];
  logic [CNT_W-1:0]  high_d   [DEPTH];
  logic [CNT_W-1:0]  reps_q   [DEPTH];
  logic [CNT_W-1:0]  reps_d   [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic              opin_q, opin_d;

  logic              loop_req;
  logic [CNT_W-1:0]  cur_p, cur_h, cur_r;
  logic [CNT_W-1:0]  nxt_p, nxt_h, nxt_r;
  logic              cur_skip, wrap, last_rep, last_step;

`ifdef PWM_STEP_SEQUENCER_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  // Table is frozen while a sequence plays so the step being generated can never change under it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      period_d[i] = period_q[i];
      high_d[i]   = high_q[i];
      reps_d[i]   = reps_q[i];
    end
    if (cfg_we && state_q != RUN) begin
      period_d[cfg_addr] = cfg_period;
      high_d[cfg_addr]   = cfg_high;
      reps_d[cfg_addr]   = cfg_reps;
    end
  end

  assign cur_p     = period_q[step_q];
  assign cur_h     = high_q[step_q];
  assign cur_r     = reps_q[step_q];
  assign cur_skip  = (cur_p == '0) || (cur_r == '0);
  assign wrap      = (cnt_q == cur_p - CNT_ONE);
  assign last_rep  = (rep_q == cur_r - CNT_ONE);
  assign last_step = ({1'b0, step_q} == len_q - LEN_ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    step_d  = step_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_len == '0) begin
            state_d = FIN;
            step_d  = '0;
          end else if (!stop) begin
            state_d = RUN;
            len_d   = cfg_len;
            step_d  = '0;
            cnt_d   = '0;
            rep_d   = '0;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cur_skip || (wrap && last_rep)) begin
          cnt_d = '0;
          rep_d = '0;
          if (!last_step) begin
            step_d = step_q + STEP_ONE;
          end else if (loop_req) begin
            step_d = '0;
          end else begin
            state_d = FIN;
          end
        end else if (wrap) begin
          cnt_d = '0;
          rep_d = rep_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // opin is computed from the upcoming step/count so the registered output lines up with busy.
  assign nxt_p  = period_q[step_d];
  assign nxt_h  = high_q[step_d];
  assign nxt_r  = reps_q[step_d];
  assign opin_d = (state_d == RUN) && (nxt_p != '0) && (nxt_r != '0) && (cnt_d < nxt_h);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      len_q   <= '0;
      step_q  <= '0;
      opin_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        period_q[i] <= '0;
        high_q[i]   <= '0;
        reps_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      len_q   <= len_d;
      step_q  <= step_d;
      opin_q  <= opin_d;
      for (int i = 0; i < DEPTH; i++) begin
        period_q[i] <= period_d[i];
        high_q[i]   <= high_d[i];
        reps_q[i]   <= reps_d[i];
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == FIN);
  assign step_idx = step_q;
  assign opin     = opin_q;

endmodule

// File: tb/tb_pwm_step_sequencer.sv
// Bench for pwm_step_sequencer: per-cycle expectation queue built from the step table, plus literal checkpoints.
module tb_pwm_step_sequencer;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CNT_W-1:0]  cfg_period, cfg_high, cfg_reps;
  logic [ADDR_W:0]   cfg_len;
  logic              start, stop, loop;
  logic              busy, done, opin;
  logic [ADDR_W-1:0] step_idx;

  always #5 clk = ~clk;

  pwm_step_sequencer #(.CNT_W(CNT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_reps(cfg_reps),
    .cfg_len(cfg_len), .start(start), .stop(stop),
`ifdef PWM_STEP_SEQUENCER_LOOP_EN
    .loop(loop),
`endif
    .busy(busy), .done(done), .step_idx(step_idx), .opin(opin)
  );

  typedef struct packed {
    logic              busy;
    logic              opin;
    logic              done;
    logic              chk;
    logic [ADDR_W-1:0] idx;
  } ent_t;

  function automatic ent_t mk(logic b, logic o, logic d, logic c, int idx);
    ent_t e;
    e.busy = b; e.opin = o; e.done = d; e.chk = c;
    e.idx  = idx[ADDR_W-1:0];
    return e;
  endfunction

  // Reference: the whole run is expanded into one expected entry per cycle.
  ent_t q[$];
  ent_t cur = '0;
  int   m_p[DEPTH], m_h[DEPTH], m_r[DEPTH];
  int   m_len;

  task automatic build();
    q.delete();
    for (int i = 0; i < m_len; i++) begin
      if (m_p[i] == 0 || m_r[i] == 0)
        q.push_back(mk(1, 0, 0, 1, i));
      else
        for (int r = 0; r < m_r[i]; r++)
          for (int c = 0; c < m_p[i]; c++)
            q.push_back(mk(1, c < m_h[i], 0, 1, i));
    end
    q.push_back(mk(0, 0, 1, 1, m_len - 1));
  endtask

  always @(posedge clk or posedge rst) begin : model
    ent_t nxt;
    if (rst) begin
      q.delete();
      cur = mk(0, 0, 0, 1, 0);
      for (int i = 0; i < DEPTH; i++) begin m_p[i] = 0; m_h[i] = 0; m_r[i] = 0; end
      m_len = 0;
    end else if (cur.busy) begin
      if (stop) begin
        q.delete();
        cur = mk(0, 0, 0, 0, cur.idx);
      end else begin
        nxt = q.pop_front();
`ifdef PWM_STEP_SEQUENCER_LOOP_EN
        if (nxt.done && loop) begin
          build();
          nxt = q.pop_front();
        end
`endif
        cur = nxt;
      end
    end else begin
      if (cfg_we) begin
        m_p[cfg_addr] = cfg_period;
        m_h[cfg_addr] = cfg_high;
        m_r[cfg_addr] = cfg_reps;
      end
      if (start && !cur.done && cfg_len == 0) begin
        cur = mk(0, 0, 1, 1, 0);
      end else if (start && !cur.done && !stop) begin
        m_len = int'(cfg_len);
        build();
        cur = q.pop_front();
      end else begin
        cur = mk(0, 0, 0, cur.chk, cur.idx);
      end
    end
  end

  int    vectors = 0;
  int    miscompares = 0;
  logic  lit_en = 1'b0;
  logic  lit_b, lit_o, lit_d, lit_c;
  logic [ADDR_W-1:0] lit_idx;
  string lit_name;

  always @(negedge clk) begin
    vectors++;
    if (busy !== cur.busy || opin !== cur.opin || done !== cur.done ||
        (cur.chk && step_idx !== cur.idx)) begin
      miscompares++;
      $display("FAIL cycle t=%0t: dut busy/opin/done/idx=%b/%b/%b/%0d, model requires %b/%b/%b/%0d",
               $time, busy, opin, done, step_idx, cur.busy, cur.opin, cur.done, cur.idx);
    end
    if (lit_en) begin
      vectors++;
      if (busy !== lit_b || opin !== lit_o || done !== lit_d || (lit_c && step_idx !== lit_idx) ||
          cur.busy !== lit_b || cur.opin !== lit_o || cur.done !== lit_d ||
          (lit_c && cur.idx !== lit_idx)) begin
        miscompares++;
        $display("FAIL %s t=%0t: dut b/o/d/idx=%b/%b/%b/%0d model=%b/%b/%b/%0d required=%b/%b/%b/%0d",
                 lit_name, $time, busy, opin, done, step_idx, cur.busy, cur.opin, cur.done, cur.idx,
                 lit_b, lit_o, lit_d, lit_idx);
      end
    end
  end

  int cyc;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic advance_to(int k);
    while (cyc < k) tick();
  endtask

  task automatic lit(string nm, logic b, logic o, logic d, logic c, int idx);
    lit_name = nm; lit_b = b; lit_o = o; lit_d = d; lit_c = c;
    lit_idx  = idx[ADDR_W-1:0];
    lit_en   = 1'b1;
    @(negedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  task automatic wr(int a, int p, int h, int r);
    cfg_we = 1'b1;
    cfg_addr = a[ADDR_W-1:0];
    cfg_period = CNT_W'(p); cfg_high = CNT_W'(h); cfg_reps = CNT_W'(r);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go_start(int len);
    cfg_len = (ADDR_W+1)'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int n, len, stop_at, wr_at;
    logic use_stop;
    rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_period = 0; cfg_high = 0; cfg_reps = 0;
    cfg_len = 0; start = 0; stop = 0; loop = 0; cyc = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lit("reset_state", 0, 0, 0, 1, 0);

    // Single step P=10 H=4 R=2
    wr(0, 10, 4, 2);
    go_start(1);
    lit("single_c0", 1, 1, 0, 1, 0);
    advance_to(3);  lit("single_c3", 1, 1, 0, 1, 0);
    advance_to(4);  lit("single_c4", 1, 0, 0, 1, 0);
    advance_to(10); lit("single_c10", 1, 1, 0, 1, 0);
    advance_to(14); lit("single_c14", 1, 0, 0, 1, 0);
    advance_to(19); lit("single_c19", 1, 0, 0, 1, 0);
    advance_to(20); lit("single_done", 0, 0, 1, 1, 0);
    advance_to(21); lit("single_idle", 0, 0, 0, 1, 0);

    // Three steps, middle one skipped
    wr(0, 5, 5, 1); wr(1, 0, 3, 4); wr(2, 4, 1, 1);
    go_start(3);
    lit("skip_c0", 1, 1, 0, 1, 0);
    advance_to(4);  lit("skip_c4", 1, 1, 0, 1, 0);
    advance_to(5);  lit("skip_c5", 1, 0, 0, 1, 1);
    advance_to(6);  lit("skip_c6", 1, 1, 0, 1, 2);
    advance_to(7);  lit("skip_c7", 1, 0, 0, 1, 2);
    advance_to(9);  lit("skip_c9", 1, 0, 0, 1, 2);
    advance_to(10); lit("skip_done", 0, 0, 1, 1, 2);
    advance_to(12);

    // Stop mid-run, then a write is accepted and used
    wr(0, 10, 4, 2);
    go_start(1);
    advance_to(7);
    stop = 1'b1;
    lit("stop_c7", 1, 0, 0, 1, 0);
    tick();
    stop = 1'b0;
    lit("stop_after", 0, 0, 0, 0, 0);
    wr(0, 6, 6, 1);
    go_start(1);
    advance_to(5); lit("post_stop_c5", 1, 1, 0, 1, 0);
    advance_to(6); lit("post_stop_done", 0, 0, 1, 1, 0);
    advance_to(8);

    // Write attempt while busy is ignored
    go_start(1);
    tick();
    cfg_we = 1'b1; cfg_addr = 0; cfg_period = 3; cfg_high = 0; cfg_reps = 1;
    tick();
    cfg_we = 1'b0;
    advance_to(8);
    go_start(1);
    lit("old_tbl_c0", 1, 1, 0, 1, 0);
    advance_to(3); lit("old_tbl_c3", 1, 1, 0, 1, 0);
    advance_to(6); lit("old_tbl_done", 0, 0, 1, 1, 0);
    advance_to(8);
    go_start(0);
    lit("len0_c0", 0, 0, 1, 1, 0);
    tick();
    lit("len0_c1", 0, 0, 0, 1, 0);

    // Asynchronous reset while opin is high in step 1
    wr(0, 2, 2, 1); wr(1, 10, 4, 2);
    go_start(2);
    advance_to(2); lit("pre_rst_c2", 1, 1, 0, 1, 1);
    tick();
    #1 rst = 1'b1;
    lit("rst_async", 0, 0, 0, 1, 0);
    tick();
    rst = 1'b0;
    tick();

`ifdef PWM_STEP_SEQUENCER_LOOP_EN
    wr(0, 4, 2, 1);
    loop = 1'b1;
    go_start(1);
    for (int c = 0; c < 14; c++) begin
      advance_to(c);
      lit("loop_run", 1, (c % 4) < 2, 0, 1, 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    lit("loop_stop", 0, 0, 0, 0, 0);
`endif

    // Randomized tables, lengths, busy writes and stops
    for (int it = 0; it < 30; it++) begin
      for (int a = 0; a < DEPTH; a++)
        if ($urandom_range(0, 3) != 0)
          wr(a, $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 3));
      len      = $urandom_range(0, DEPTH);
      use_stop = ($urandom_range(0, 3) == 0);
      stop_at  = $urandom_range(0, 30);
      wr_at    = $urandom_range(0, 20);
      go_start(len);
      n = 0;
      while ((cur.busy || cur.done) && n < 400) begin
        if (n == wr_at) begin
          cfg_we = 1'b1;
          cfg_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
          cfg_period = CNT_W'($urandom_range(0, 6));
          cfg_high = CNT_W'($urandom_range(0, 7));
          cfg_reps = CNT_W'($urandom_range(0, 3));
        end
        if (use_stop && n == stop_at) stop = 1'b1;
        tick();
        cfg_we = 1'b0;
        stop = 1'b0;
        n++;
      end
      lit("rand_idle", 0, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pwm_step_sequencer.md
Name: pwm_step_sequencer

Overview:
- Drives a single waveform output `opin` through a programmed list of PWM steps.
- Each step has a period P, a high time H and a repeat count R; steps play back to back.
- Acts as the controller and configurator for the counter-based waveform generation used in this codebase.
- A host loads the step table while idle, pulses `start`, and watches `busy`/`done`.

Parameters:
- CNT_W, 16, width of period, high-time and repeat fields.
- DEPTH, 4, number of step-table entries.
- ADDR_W, 2, table address width; must satisfy 2**ADDR_W == DEPTH.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  ADDR_W  table entry written.
- cfg_period  in  CNT_W  P for the entry.
- cfg_high  in  CNT_W  H for the entry.
- cfg_reps  in  CNT_W  R for the entry.
- cfg_len  in  ADDR_W+1  number of steps to play (0..DEPTH); sampled on start.
- start  in  1  single-cycle start request.
- stop  in  1  abort request.
- busy  out  1  high while a sequence is playing.
- done  out  1  one-cycle pulse on normal completion.
- step_idx  out  ADDR_W  current step index.
- opin  out  1  waveform output.

Behaviour:
- Reset (asynchronous, immediate):
  - opin=0, busy=0, done=0, step_idx=0.
  - Internal period, repeat and length registers = 0; all table entries = 0; FSM = IDLE.
- FSM states: IDLE, RUN, FIN.
- Table writes:
  - Accepted on an edge with cfg_we=1 and busy=0.
  - Ignored while busy=1; the table keeps its old contents.
- IDLE:
  - On an edge with start=1, stop=0 and cfg_len!=0: latch len, step=0, cnt=0, rep=0, go to RUN; busy=1 at that edge.
  - On an edge with start=1 and cfg_len==0: go to FIN without asserting busy.
- RUN, per edge:
  - opin is registered and updated on the same edge as cnt, so it is aligned with busy.
  - opin = 1 when cnt < H of the current step, else 0. H >= P gives opin high for the whole period; H=0 gives opin low for the whole period.
  - When cnt == P-1: cnt wraps to 0 and rep increments.
  - When rep == R-1 at that wrap: rep=0 and step advances.
  - Advancing past step len-1 goes to FIN.
  - Step duration is P*R cycles.
  - A step with P=0 or R=0 is skipped: it occupies exactly 1 cycle with opin=0, then advances.
- Arithmetic: cnt and rep are CNT_W bits, unsigned; compares are unsigned; no overflow is possible because terminal values are checked before incrementing.
- FIN:
  - done=1, busy=0, opin=0 for exactly one cycle.
  - step_idx holds the last value; the FSM then returns to IDLE.
- step_idx = current step while in RUN; reset to 0 on the next start.
- stop:
  - From RUN: at the next edge go to IDLE with opin=0, busy=0, no done pulse.
  - stop beats start on the same edge.
  - stop in IDLE or FIN has no effect.
- start while busy=1 is ignored.
- Reset mid-run returns immediately to the reset state.

Optional Feature:
- Macro: PWM_STEP_SEQUENCER_LOOP_EN.
- Defined:
  - Adds an input port `loop` (1 bit), sampled on each wrap from the last step.
  - If loop=1: the sequence restarts at step 0 with no idle cycle and no done pulse, and busy stays high until stop.
  - If loop=0: normal FIN.
- Undefined: no `loop` port; the sequence is always one-shot.

Test Plan:
- Reset during RUN with opin=1 -> opin, busy, done and step_idx go to 0 immediately, without waiting for a clock edge.
- Single step: len=1, P=10, H=4, R=2, start at edge 0.
  - busy=1 on cycles 0..19; opin=1 on cycles 0-3 and 10-13, 0 otherwise.
  - done=1 on cycle 20 only.
- Two steps with a skip: len=3, entries {P=5,H=5,R=1}, {P=0,H=3,R=4}, {P=4,H=1,R=1}.
  - opin: 5 cycles high, 1 cycle low (skipped step), then 1 high and 3 low.
  - step_idx goes 0,1,2; done arrives 10 cycles after start.
- stop asserted on cycle 7 of a P=10, H=4, R=2 run -> next cycle busy=0, opin=0, no done pulse; a table write is then accepted.
- Config write during busy to addr 0 -> table unchanged; the next run uses the old values. start with cfg_len=0 -> busy stays 0 and done pulses 1 cycle later.
- With PWM_STEP_SEQUENCER_LOOP_EN, loop=1, len=1, P=4, H=2, R=1 -> opin continuously 1,1,0,0 for more than 3 periods with no done pulse; stop ends the run.
